// File: rtl/sdram_arbiter.sv
// Single-word SDRAM request arbiter for the load/mix/pitch/record/play cores.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; fixed priority (play highest) otherwise.
module sdram_arbiter #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32,
   parameter int N_CLI  = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_CLI-1:0]          cli_read,
   input  logic [N_CLI-1:0]          cli_write,
   input  logic [N_CLI*ADDR_W-1:0]   cli_addr,
   input  logic [N_CLI*DATA_W-1:0]   cli_writedata,
   output logic [DATA_W-1:0]         cli_readdata,
   output logic [N_CLI-1:0]          cli_finished,
   output logic                      sdram_read,
   output logic                      sdram_write,
   output logic [ADDR_W-1:0]         sdram_addr,
   output logic [DATA_W-1:0]         sdram_writedata,
   input  logic [DATA_W-1:0]         sdram_readdata,
   input  logic                      sdram_finished,
   output logic [2:0]                grant_id,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_r;
   logic                op_read_r;
   logic [N_CLI-1:0]    req_s;
   logic                any_req_s;
   logic [2:0]          win_s;
   logic                sel_rd_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;

   // Highest index wins, so play(4) beats everyone.
   function automatic logic [2:0] pick_fixed(input logic [N_CLI-1:0] req);
      logic [2:0] w;
      w = 3'd0;
      for (int i = 0; i < N_CLI; i++) begin
         w = req[i] ? 3'(i) : w;
      end
      return w;
   endfunction

   function automatic logic [N_CLI-1:0] one_hot(input logic [2:0] idx);
      logic [N_CLI-1:0] v;
      v = '0;
      for (int i = 0; i < N_CLI; i++) begin
         v[i] = (idx == 3'(i));
      end
      return v;
   endfunction

`ifdef SDRAM_ARB_RR_EN
   logic [2:0] rr_ptr_r;

   // Walk backwards from the farthest slot so the first requester in circular order is kept.
   function automatic logic [2:0] pick_rr(input logic [N_CLI-1:0] req, input logic [2:0] ptr);
      logic [2:0] w;
      int         idx;
      w = 3'd0;
      for (int k = N_CLI - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_CLI;
         w   = req[idx] ? 3'(idx) : w;
      end
      return w;
   endfunction

   // Rotation pointer: search start for the next grant, one past the last winner.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rr_ptr_r <= 3'd0;
      end else if ((state_r == IDLE) && any_req_s) begin
         rr_ptr_r <= (win_s == 3'(N_CLI - 1)) ? 3'd0 : (win_s + 3'd1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`endif

   // Request decode, winner selection and winner slice mux.
   always_comb begin
      req_s     = cli_read | cli_write;
      any_req_s = |req_s;
`ifdef SDRAM_ARB_RR_EN
      win_s     = pick_rr(req_s, rr_ptr_r);
`else
      win_s     = pick_fixed(req_s);
`endif
      sel_rd_s    = 1'b0;
      sel_addr_s  = '0;
      sel_wdata_s = '0;
      for (int i = 0; i < N_CLI; i++) begin
         sel_rd_s    = (win_s == 3'(i)) ? cli_read[i] : sel_rd_s;
         sel_addr_s  = (win_s == 3'(i)) ? cli_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
         sel_wdata_s = (win_s == 3'(i)) ? cli_writedata[i*DATA_W +: DATA_W] : sel_wdata_s;
      end
   end

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r         <= IDLE;
         op_read_r       <= 1'b0;
         grant_id        <= 3'd0;
         sdram_read      <= 1'b0;
         sdram_write     <= 1'b0;
         sdram_addr      <= '0;
         sdram_writedata <= '0;
         cli_readdata    <= '0;
         cli_finished    <= '0;
         busy            <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               cli_finished <= '0;
               if (any_req_s) begin
                  // Read wins over write when a client raises both.
                  grant_id        <= win_s;
                  op_read_r       <= sel_rd_s;
                  sdram_read      <= sel_rd_s;
                  sdram_write     <= ~sel_rd_s;
                  sdram_addr      <= sel_addr_s;
                  sdram_writedata <= sel_wdata_s;
                  busy            <= 1'b1;
                  state_r         <= BUSY;
               end else begin
                  sdram_read  <= 1'b0;
                  sdram_write <= 1'b0;
                  busy        <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            BUSY: begin
               if (sdram_finished) begin
                  sdram_read   <= 1'b0;
                  sdram_write  <= 1'b0;
                  cli_readdata <= op_read_r ? sdram_readdata : cli_readdata;
                  cli_finished <= one_hot(grant_id);
                  state_r      <= DONE;
               end else begin
                  state_r <= BUSY;
               end
            end
            DONE: begin
               cli_finished <= '0;
               busy         <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               sdram_read   <= 1'b0;
               sdram_write  <= 1'b0;
               cli_finished <= '0;
               busy         <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table of single transactions plus hand sequences.
module tb_sdram_arbiter;
   localparam int AW = 23;
   localparam int DW = 32;
   localparam int N  = 5;

   logic            clk;
   logic            rst;
   logic [N-1:0]    cli_read;
   logic [N-1:0]    cli_write;
   logic [N*AW-1:0] cli_addr;
   logic [N*DW-1:0] cli_writedata;
   logic [DW-1:0]   cli_readdata;
   logic [N-1:0]    cli_finished;
   logic            sdram_read;
   logic            sdram_write;
   logic [AW-1:0]   sdram_addr;
   logic [DW-1:0]   sdram_writedata;
   logic [DW-1:0]   sdram_readdata;
   logic            sdram_finished;
   logic [2:0]      grant_id;
   logic            busy;

   int checks = 0;
   int errors = 0;

   sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_CLI(N)) dut (
      .i_clk(clk), .i_rst(rst),
      .cli_read(cli_read), .cli_write(cli_write),
      .cli_addr(cli_addr), .cli_writedata(cli_writedata),
      .cli_readdata(cli_readdata), .cli_finished(cli_finished),
      .sdram_read(sdram_read), .sdram_write(sdram_write),
      .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
      .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
      .grant_id(grant_id), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not end, got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic [4:0]  rd;
      logic [4:0]  wr;
      int          lat;
      logic [31:0] rdata;
      logic [2:0]  grant;
      logic        exp_rd;
      logic [22:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one granted transaction starting from an IDLE cycle with requests already driven.
   task automatic do_txn(input logic [2:0] g, input logic rd, input logic [22:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rdat,
                         input logic [31:0] exp_rdat, input logic [4:0] drop);
      tick();
      chk("grant_id", 64'(grant_id), 64'(g));
      chk("sdram_rw_start", 64'({sdram_read, sdram_write}), 64'({rd, ~rd}));
      chk("sdram_addr", 64'(sdram_addr), 64'(a));
      chk("sdram_writedata", 64'(sdram_writedata), 64'(wd));
      chk("busy_start", 64'(busy), 64'd1);
      for (int c = 1; c < lat; c++) tick();
      chk("sdram_rw_held", 64'({sdram_read, sdram_write}), 64'({rd, ~rd}));
      sdram_finished = 1'b1;
      sdram_readdata = rdat;
      tick();
      sdram_finished = 1'b0;
      sdram_readdata = 32'hA5A5_5A5A;
      chk("cli_finished", 64'(cli_finished), 64'(5'b00001 << g));
      chk("cli_readdata", 64'(cli_readdata), 64'(exp_rdat));
      chk("sdram_rw_drop", 64'({sdram_read, sdram_write}), 64'd0);
      cli_read  = cli_read & ~drop;
      cli_write = cli_write & ~drop;
      tick();
      chk("busy_end", 64'(busy), 64'd0);
      chk("cli_finished_end", 64'(cli_finished), 64'd0);
   endtask

   logic [2:0]  c_order[3];
   logic [31:0] c_exp[3];

   initial begin
      vecs[0] = '{rd: 5'b10000, wr: 5'b00000, lat: 4, rdata: 32'hDEADBEEF, grant: 3'd4, exp_rd: 1'b1,
                  addr: 23'h000100, wd: 32'h0000_0000, exp_rdata: 32'hDEADBEEF};
      vecs[1] = '{rd: 5'b00000, wr: 5'b01000, lat: 2, rdata: 32'hBAD0BAD0, grant: 3'd3, exp_rd: 1'b0,
                  addr: 23'h7FFFFF, wd: 32'h12345678, exp_rdata: 32'hDEADBEEF};
      vecs[2] = '{rd: 5'b00100, wr: 5'b00100, lat: 1, rdata: 32'h0BADF00D, grant: 3'd2, exp_rd: 1'b1,
                  addr: 23'h000ABC, wd: 32'hCAFEF00D, exp_rdata: 32'h0BADF00D};
      vecs[3] = '{rd: 5'b00001, wr: 5'b00000, lat: 3, rdata: 32'h00000001, grant: 3'd0, exp_rd: 1'b1,
                  addr: 23'h012345, wd: 32'h00C0FFEE, exp_rdata: 32'h00000001};

      rst = 1'b0;
      cli_read = '0; cli_write = '0; cli_addr = '0; cli_writedata = '0;
      sdram_readdata = '0; sdram_finished = 1'b0;
      tick();
      tick();
      chk("reset_rw", 64'({sdram_read, sdram_write, busy}), 64'd0);
      chk("reset_grant", 64'(grant_id), 64'd0);
      chk("reset_readdata", 64'(cli_readdata), 64'd0);
      chk("reset_finished", 64'(cli_finished), 64'd0);
      rst = 1'b1;
      tick();
      chk("idle_no_req", 64'({sdram_read, sdram_write, busy}), 64'd0);

      // Non-winning clients get an address/data that differs in the top bits.
      for (int v = 0; v < 4; v++) begin
         cli_read  = vecs[v].rd;
         cli_write = vecs[v].wr;
         for (int i = 0; i < N; i++) begin
            cli_addr[i*AW +: AW]      = vecs[v].addr ^ {3'(i) ^ vecs[v].grant, 20'h0};
            cli_writedata[i*DW +: DW] = vecs[v].wd ^ {1'b0, 3'(i) ^ vecs[v].grant, 28'h0};
         end
         do_txn(vecs[v].grant, vecs[v].exp_rd, vecs[v].addr, vecs[v].wd, vecs[v].lat,
                vecs[v].rdata, vecs[v].exp_rdata, 5'b11111);
      end

      sdram_finished = 1'b1;
      sdram_readdata = 32'hFFFF_FFFF;
      tick();
      sdram_finished = 1'b0;
      chk("spurious_finished", 64'(cli_finished), 64'd0);
      chk("spurious_busy", 64'(busy), 64'd0);
      chk("spurious_readdata", 64'(cli_readdata), 64'h00000001);

      cli_addr = '0; cli_writedata = '0;
      cli_addr[4*AW +: AW] = 23'h000010;
      cli_read = 5'b10000;
      tick();
      chk("stab_addr_first", 64'(sdram_addr), 64'h10);
      cli_addr[4*AW +: AW] = 23'h000020;
      tick();
      tick();
      chk("stab_addr_held", 64'(sdram_addr), 64'h10);
      chk("stab_read_held", 64'(sdram_read), 64'd1);
      cli_read = 5'b00000;
      tick();
      chk("stab_drop_no_abort", 64'({sdram_read, busy}), 64'b11);
      sdram_finished = 1'b1;
      sdram_readdata = 32'h11112222;
      tick();
      sdram_finished = 1'b0;
      chk("stab_finished", 64'(cli_finished), 64'b10000);
      chk("stab_readdata", 64'(cli_readdata), 64'h11112222);
      tick();
      chk("stab_idle", 64'(busy), 64'd0);

`ifdef SDRAM_ARB_RR_EN
      c_order = '{3'd0, 3'd1, 3'd4};
      c_exp   = '{32'h10000000, 32'h10000000, 32'h10000004};
`else
      c_order = '{3'd4, 3'd1, 3'd0};
      c_exp   = '{32'h10000004, 32'h10000004, 32'h10000000};
`endif
      cli_addr = '0; cli_writedata = '0;
      cli_addr[0*AW +: AW]      = 23'h000AAA;
      cli_addr[1*AW +: AW]      = 23'h000BBB;
      cli_addr[4*AW +: AW]      = 23'h000CCC;
      cli_writedata[1*DW +: DW] = 32'h55AA55AA;
      cli_read  = 5'b10001;
      cli_write = 5'b00010;
      for (int k = 0; k < 3; k++) begin
         do_txn(c_order[k], c_order[k] != 3'd1,
                (c_order[k] == 3'd0) ? 23'h000AAA : (c_order[k] == 3'd1) ? 23'h000BBB : 23'h000CCC,
                (c_order[k] == 3'd1) ? 32'h55AA55AA : 32'h0, 2,
                32'h10000000 | 32'(c_order[k]), c_exp[k], 5'b00001 << c_order[k]);
      end

      cli_read = 5'b00010;
      tick();
      chk("rst_pre_busy", 64'({sdram_read, busy}), 64'b11);
      #3 rst = 1'b0;
      #1;
      chk("rst_async_rw", 64'({sdram_read, sdram_write, busy}), 64'd0);
      chk("rst_async_fin", 64'(cli_finished), 64'd0);
      chk("rst_async_state", 64'({grant_id, cli_readdata}), 64'd0);
      #1 rst = 1'b1;
      do_txn(3'd1, 1'b1, 23'h000BBB, 32'h55AA55AA, 1, 32'h600DCAFE, 32'h600DCAFE, 5'b11111);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Arbitrates SDRAM access among the five cores: load, mix, pitch, record and play. It replaces the hard-wired play/record assignment currently driving the SDRAM bus request interface. The block grants one single-word read or write transaction at a time. It latches the request, drives it downstream until sdram_finished, then routes readdata and a finished pulse back to the granted client.

Parameters:
ADDR_W, 23, SDRAM word address width
DATA_W, 32, SDRAM data width
N_CLI, 5, number of clients; fixed indices 0=load, 1=mix, 2=pitch, 3=record, 4=play

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-low
cli_read  in  N_CLI  per-client read request, level, held until that client's finished pulse
cli_write  in  N_CLI  per-client write request, level, held until that client's finished pulse
cli_addr  in  N_CLI*ADDR_W  packed addresses; client i at bits [i*ADDR_W +: ADDR_W]
cli_writedata  in  N_CLI*DATA_W  packed write data; client i at bits [i*DATA_W +: DATA_W]
cli_readdata  out  DATA_W  registered read data, broadcast to all clients
cli_finished  out  N_CLI  one-cycle completion pulse, one-hot to the granted client
sdram_read  out  1  read request to the SDRAM bus
sdram_write  out  1  write request to the SDRAM bus
sdram_addr  out  ADDR_W  latched address
sdram_writedata  out  DATA_W  latched write data
sdram_readdata  in  DATA_W  read data from the SDRAM bus, valid with sdram_finished
sdram_finished  in  1  one-cycle transaction-complete pulse from the SDRAM bus
grant_id  out  3  index of the current or last granted client
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE; all outputs 0, including grant_id and cli_readdata.
- A client requests when cli_read[i] | cli_write[i]. If both are set, the read is served and the write is ignored for that transaction.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any client is requesting, select a winner and register the following at the clock edge:
  - grant_id = winner
  - operation (read or write)
  - sdram_addr and sdram_writedata from the winner's slice
  - sdram_read or sdram_write = 1
  - go to BUSY.
- IDLE with no request: stay in IDLE, all request outputs 0.
- Default priority (fixed): play(4) > record(3) > pitch(2) > mix(1) > load(0).
- BUSY:
  - Hold sdram_read/sdram_write, sdram_addr and sdram_writedata stable.
  - On sdram_finished=1: drop sdram_read/sdram_write at that edge. For a read, register sdram_readdata into cli_readdata. Set cli_finished[grant_id]=1. Go to DONE.
- DONE: cli_finished is high for exactly this cycle; next state is IDLE. The client deasserts its request on the edge leaving DONE, so the IDLE cycle that follows cannot re-grant a stale request.
- Latency: request seen in IDLE at cycle 0 -> sdram_read/sdram_write high at cycle 1 -> sdram_finished at cycle k -> cli_finished at cycle k+1 -> IDLE at cycle k+2, ready to grant.
- Minimum turnaround between grants: 3 cycles plus the SDRAM bus latency.
- Request inputs are sampled only in IDLE:
  - Changes to cli_addr or cli_writedata during BUSY have no effect.
  - A client dropping its request during BUSY does not abort the transaction; it still receives cli_finished.
- sdram_finished outside BUSY is ignored.
- cli_readdata holds its last value until the next completed read; it is not updated on writes.
- Reset mid-transaction: immediate return to IDLE with outputs cleared. The SDRAM bus shares i_rst, so no pending transaction survives.

Optional Feature:
SDRAM_ARB_RR_EN:
- Defined: round-robin arbitration. The search starts at (grant_id+1) mod N_CLI and the first requester in circular order wins. A rotation pointer of 0 is used after reset.
- Undefined: fixed priority as above. No rotation pointer logic is synthesized.

Test Plan:
- Single read: cli_read[4]=1, addr=0x000100; bus returns finished with sdram_readdata=0xDEADBEEF 4 cycles after grant -> sdram_read high for cycles 1..4; cli_readdata=0xDEADBEEF and cli_finished=5'b10000 at cycle 5; busy=0 at cycle 6.
- Single write: cli_write[3]=1, addr=0x7FFFFF, data=0x12345678 -> sdram_write=1, sdram_addr=0x7FFFFF, sdram_writedata=0x12345678 until finished; cli_finished=5'b01000; cli_readdata unchanged.
- Contention: cli_read[0], cli_write[1] and cli_read[4] all asserted at cycle 0, each client dropping its request after its finished pulse -> grant order 4, 1, 0 (fixed priority); with SDRAM_ARB_RR_EN, starting from grant_id=4 after a prior grant, order 0, 1, 4.
- Stability: change cli_addr[4] from 0x10 to 0x20 mid-BUSY -> sdram_addr remains 0x10; a spurious sdram_finished in IDLE produces no cli_finished pulse.
- Both read and write asserted on client 2 -> only sdram_read is asserted; exactly one cli_finished pulse.
- Assert i_rst=0 in BUSY asynchronously (between edges) -> sdram_read=0, busy=0 and cli_finished=0 immediately; after release, a pending request is granted on the first IDLE cycle.
